// File: rtl/mult_share_arbiter.sv
// Round-robin front end for one shared 4x4 multiplier.
// Latches the winner's operands, waits MUL_LAT cycles, returns the product.
module mult_share_arbiter #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_p,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_prod,
    output logic       rsp_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t     state;
    state_t     state_nx;
    logic       last_grant;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       any_grant;

    // Grant selection: only in IDLE; on contention favour the requester
    // that did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign any_grant  = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    // Next-state logic for the IDLE -> WAIT -> RESP cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (any_grant) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand latch, settle counter and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a      <= 4'd0;
            mul_b      <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_prod   <= 8'd0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_grant) begin
                        mul_a      <= grant1 ? req1_a : req0_a;
                        mul_b      <= grant1 ? req1_b : req0_b;
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                        cnt        <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_prod  <= mul_p;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural multiplier.
// Random and directed traffic, responses checked by a queue-based monitor.
module tb_mult_share_arbiter;

    localparam int LAT = 3;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [7:0] mul_p;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_prod;
    logic       rsp_id;
    logic       busy;

    typedef struct {
        logic [7:0] prod;
        logic       id;
        int         due;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    // Behavioural stand-in for the shared array multiplier.
    assign mul_p = 8'(mul_a) * 8'(mul_b);

    mult_share_arbiter #(.MUL_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Reference model: operation-level view (who wins, when the result
    // is due, what it must be), advanced once per cycle.
    logic       started;
    logic       m_busy;
    logic       m_rv;
    logic       m_last;
    logic       m_id;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [7:0] m_prod;
    int         m_due;

    initial started = 1'b0;

    always @(negedge clk) begin
        logic g0;
        logic g1;
        if (started) begin
            g0 = !m_busy && req0_valid && (!req1_valid || m_last);
            g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("mul_a", mul_a, m_a);
            chk("mul_b", mul_b, m_b);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_prod", rsp_prod, m_prod);
            chk("req0_ready", req0_ready, g0);
            chk("req1_ready", req1_ready, g1);
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
        if (!rst_n) begin
            started = 1'b1;
            m_busy  = 1'b0;
            m_rv    = 1'b0;
            m_last  = 1'b1;
            m_id    = 1'b0;
            m_a     = 4'd0;
            m_b     = 4'd0;
            m_prod  = 8'd0;
            m_due   = 0;
            q.delete();
        end else if (started) begin
            if (g0 || g1) begin
                m_busy = 1'b1;
                m_a    = g1 ? req1_a : req0_a;
                m_b    = g1 ? req1_b : req0_b;
                m_id   = g1;
                m_last = g1;
                m_due  = cyc + 1 + LAT;
                q.push_back('{prod: 8'(m_a * m_b), id: g1, due: m_due});
            end else if (m_busy && !m_rv && cyc + 1 == m_due) begin
                m_rv   = 1'b1;
                m_prod = 8'(m_a * m_b);
            end else if (m_rv && rsp_ready) begin
                m_rv   = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the expected response whenever the DUT presents one.
    logic seen;
    initial seen = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (q.size() == 0) begin
                chk("spurious_rsp", 1, 0);
            end else begin
                if (!seen) begin
                    chk("rsp_latency", cyc, q[0].due);
                    seen = 1'b1;
                end
                chk("mon_prod", rsp_prod, q[0].prod);
                chk("mon_id", rsp_id, q[0].id);
                if (rsp_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            chk("rsp_timeout", cyc, q[0].due);
            void'(q.pop_front());
        end
    end

    task automatic drive(input logic v0, input logic [3:0] a0,
                         input logic [3:0] b0, input logic v1,
                         input logic [3:0] a1, input logic [3:0] b1,
                         input logic rr, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            req0_valid = v0;
            req0_a     = a0;
            req0_b     = b0;
            req1_valid = v1;
            req1_a     = a1;
            req1_b     = b1;
            rsp_ready  = rr;
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_a     = 4'd0;
        req0_b     = 4'd0;
        req1_valid = 1'b0;
        req1_a     = 4'd0;
        req1_b     = 4'd0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request 3x5.
        drive(1, 4'd3, 4'd5, 0, 4'd0, 4'd0, 1, 1);
        drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 8);

        // Continuous contention: grants must alternate.
        drive(1, 4'd15, 4'd15, 1, 4'd2, 4'd7, 1, 24);

        // Single requester 1 with 9x9.
        drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 4);
        drive(0, 4'd0, 4'd0, 1, 4'd9, 4'd9, 1, 1);
        drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 8);

        // Backpressure while both keep requesting.
        drive(1, 4'd7, 4'd3, 1, 4'd4, 4'd11, 0, 12);
        drive(1, 4'd7, 4'd3, 1, 4'd4, 4'd11, 1, 10);

        // Reset during WAIT, then contention restarts at requester 0.
        drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 8);
        drive(0, 4'd0, 4'd0, 1, 4'd6, 4'd6, 1, 1);
        drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 1);
        rst_n = 1'b0;
        drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 1);
        rst_n = 1'b1;
        drive(1, 4'd12, 4'd10, 1, 4'd5, 4'd13, 1, 12);

        // Zero operand from a lone requester.
        drive(1, 4'd0, 4'd13, 0, 4'd0, 4'd0, 1, 24);
        drive(1, 4'd1, 4'd1, 1, 4'd1, 4'd2, 1, 6);

        // Randomised traffic with occasional resets and stalls.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_a     = 4'($urandom_range(0, 15));
            req0_b     = 4'($urandom_range(0, 15));
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_a     = 4'($urandom_range(0, 15));
            req1_b     = 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            rst_n      = ($urandom_range(0, 299) != 0);
        end

        rst_n = 1'b1;
        drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 12);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
